burst_rdmem_model: RTL and testbench
====================================

Name: burst_rdmem_model

Overview:
- Parametrised burst-read memory responder for cache benches (icache, later dcache).
- Accepts line-fill read requests into a request queue and returns exactly BURST_LEN = 2^BURST_LOG2 beats per request after a programmable latency.
- Each beat carries a self-checking address pattern.
- Supersedes the fixed 32-beat, single-request, no-backpressure responder; adds a queue, an acknowledge, a last-beat flag and configurable latency.

Parameters:
- ADDR_W, 32: request address width.
- DATA_W, 32: data beat width; must be >= ADDR_W.
- BURST_LOG2, 5: log2 of beats per burst (default 32 beats).
- LATENCY, 2: idle cycles between a request being popped and its first beat (0 allowed).
- QDEPTH, 4: request queue depth; power of two, >= 1.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- mem_rdaddr  in  ADDR_W  request address; low BURST_LOG2 bits ignored (line aligned)
- mem_rdreq  in  1  request strobe; one request per cycle while high
- mem_rdack  out  1  combinational: mem_rdreq & ~queue_full; request captured at this edge
- mem_dataout  out  DATA_W  beat data
- mem_datavalid  out  1  beat valid, registered
- mem_last  out  1  high with the final beat of each burst, registered
- mem_busy  out  1  high when the queue is non-empty or the engine is not IDLE
- mem_qlevel  out  $clog2(QDEPTH+1)  number of queued, not yet popped requests

Behaviour:
- Reset (asynchronous, reset_n low):
  - queue emptied; state IDLE; counters 0.
  - mem_datavalid=0, mem_last=0, mem_dataout=0, mem_busy=0, mem_qlevel=0.
  - A reset mid-burst or mid-wait aborts the burst and drops all queued requests. No beat appears after reset release until a new request is accepted.
- Queue:
  - FIFO of aligned line addresses {addr[ADDR_W-1:BURST_LOG2], zeros}.
  - A push occurs when mem_rdack=1.
  - When full, mem_rdack=0 even if a pop happens in the same cycle (no pass-through on full).
  - A push into an empty queue is not visible to the pop in the same cycle; there is no bypass.
  - Simultaneous push and pop on a non-full, non-empty queue leaves mem_qlevel unchanged.
- Engine FSM:
  - IDLE: if the queue is non-empty, pop it, latch the line address, set beat=0, wcnt=LATENCY, and go to WAIT. If LATENCY==0, go directly to BURST.
  - WAIT: decrement wcnt; when wcnt==1, go to BURST on the next edge. The number of WAIT cycles is exactly LATENCY.
  - BURST: each cycle, register mem_datavalid=1 and mem_dataout = zero-extend({line[ADDR_W-1:BURST_LOG2], beat[BURST_LOG2-1:0]}), then increment beat.
    - mem_last=1 on beat == BURST_LEN-1.
    - On the last beat: if the queue is non-empty, pop it and go to WAIT, or straight to BURST when LATENCY==0, giving gapless back-to-back bursts. Otherwise go to IDLE.
- Beat order and counting:
  - Beats are in incrementing order 0..BURST_LEN-1.
  - Exactly BURST_LEN valid cycles per request; the beat counter wraps naturally at BURST_LEN.
- Timing:
  - A request accepted at edge E0 into an empty, idle model is popped at E1.
  - Its first beat is registered at edge E1+LATENCY+1, last beat at E1+LATENCY+BURST_LEN.
  - Latency from accept to first beat = LATENCY+2 edges.
- Output hold: when mem_datavalid=0, mem_dataout holds the last beat value and mem_last=0.
- mem_busy is a combinational OR of queue-non-empty and state!=IDLE.

Test Plan:
- Defaults. Single request 0x00000000 -> ack same cycle; 32 valid beats 0x00000000..0x0000001F, first beat 4 edges after accept; mem_last only on 0x1F; valid low afterwards; busy drops with the last beat.
- Unaligned request 0x2000001C -> beats 0x20000000..0x2000001F; low address bits ignored.
- Requests 0x00000040 then 0x00000080 in consecutive cycles, LATENCY=0 -> 64 contiguous valid cycles; mem_last at 0x5F and 0x9F; qlevel sequence 1,1,0 as requests are accepted and popped.
- Hold mem_rdreq high for 8 cycles while busy, QDEPTH=4 -> acks for the first 4 plus one more after each pop; mem_rdack=0 while qlevel=4; every acked address bursts exactly once, in order.
- Assert reset_n low asynchronously at beat 10 with 2 requests queued -> datavalid, last, busy and qlevel go to 0 immediately; no further beats after release until a new request.
- BURST_LOG2=2, DATA_W=64, LATENCY=3, request 0x100 -> 4 beats 0x100..0x103 zero-extended to 64 bits; first beat 5 edges after accept.

Source files
------------

// File: rtl/burst_rdmem_model_if.sv
// Request/response bus between a cache under test and the burst-read memory model.
// The cache side uses the master modport, the memory model uses the slave modport.
interface burst_rdmem_model_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int QLVL_W = 3
);
    logic [ADDR_W-1:0] mem_rdaddr;
    logic              mem_rdreq;
    logic              mem_rdack;
    logic [DATA_W-1:0] mem_dataout;
    logic              mem_datavalid;
    logic              mem_last;
    logic              mem_busy;
    logic [QLVL_W-1:0] mem_qlevel;

    modport master (
        output mem_rdaddr, mem_rdreq,
        input  mem_rdack, mem_dataout, mem_datavalid, mem_last, mem_busy, mem_qlevel
    );

    modport slave (
        input  mem_rdaddr, mem_rdreq,
        output mem_rdack, mem_dataout, mem_datavalid, mem_last, mem_busy, mem_qlevel
    );
endinterface

// File: rtl/burst_rdmem_model.sv
// Burst-read memory responder: queues line-fill requests and, after LATENCY idle
// cycles, returns 2^BURST_LOG2 beats per request whose data is the beat address.
module burst_rdmem_model #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BURST_LOG2 = 5,
    parameter int LATENCY    = 2,
    parameter int QDEPTH     = 4
) (
    input logic                clk,
    input logic                reset_n,
    burst_rdmem_model_if.slave bus
);
    localparam int QLVL_W = $clog2(QDEPTH + 1);
    localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int LINE_W = ADDR_W - BURST_LOG2;
    localparam int WCNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t              state, next_state;
    logic [LINE_W-1:0]   q_mem [QDEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [QLVL_W-1:0]   q_count;
    logic                q_full, q_empty;
    logic                push, pop;
    logic [LINE_W-1:0]   line;
    logic [BURST_LOG2-1:0] beat;
    logic                beat_last;
    logic [WCNT_W-1:0]   wcnt;
    logic                beat_valid;
    logic [DATA_W-1:0]   beat_data;
    logic                datavalid_q, last_q;
    logic [DATA_W-1:0]   dataout_q;
    logic [BURST_LOG2-1:0] unused_addr_bits;

    // Requests are line aligned, so the in-line offset bits are deliberately dropped.
    assign unused_addr_bits = bus.mem_rdaddr[BURST_LOG2-1:0];

    assign q_full    = (q_count == QLVL_W'(QDEPTH));
    assign q_empty   = (q_count == '0);
    assign push      = bus.mem_rdreq & ~q_full;
    assign beat_last = (beat == '1);

    assign bus.mem_rdack     = push;
    assign bus.mem_datavalid = datavalid_q;
    assign bus.mem_last      = last_q;
    assign bus.mem_dataout   = dataout_q;
    assign bus.mem_busy      = ~q_empty | (state != IDLE);
    assign bus.mem_qlevel    = q_count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Engine state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic; LATENCY==0 skips WAIT so back-to-back bursts stay gapless.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (!q_empty) next_state = (LATENCY == 0) ? BURST : WAIT;
            WAIT:  if (wcnt == WCNT_W'(1)) next_state = BURST;
            BURST: if (beat_last) begin
                       if (q_empty) next_state = IDLE;
                       else         next_state = (LATENCY == 0) ? BURST : WAIT;
                   end
            default: next_state = IDLE;
        endcase
    end

    // Pop decision and the beat about to be registered.
    always_comb begin
        pop        = 1'b0;
        beat_valid = 1'b0;
        beat_data  = '0;
        beat_data[ADDR_W-1:0] = {line, beat};
        case (state)
            IDLE:    pop = ~q_empty;
            BURST: begin
                beat_valid = 1'b1;
                pop        = beat_last & ~q_empty;
            end
            default: ;
        endcase
    end

    // Queue pointers and occupancy; a full queue refuses pushes even when popping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      q_count <= q_count + 1'b1;
            else if (!push && pop) q_count <= q_count - 1'b1;
        end
    end

    // Queue storage holds only the line part of each address.
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= bus.mem_rdaddr[ADDR_W-1:BURST_LOG2];
    end

    // Engine datapath: latch the popped line, count wait cycles and beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line <= '0;
            beat <= '0;
            wcnt <= '0;
        end else if (pop) begin
            line <= q_mem[rd_ptr];
            beat <= '0;
            wcnt <= WCNT_W'(LATENCY);
        end else begin
            if (state == WAIT)  wcnt <= wcnt - 1'b1;
            if (state == BURST) beat <= beat + 1'b1;
        end
    end

    // Registered beat outputs; data holds its last value between bursts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            datavalid_q <= 1'b0;
            last_q      <= 1'b0;
            dataout_q   <= '0;
        end else begin
            datavalid_q <= beat_valid;
            last_q      <= beat_valid & beat_last;
            if (beat_valid) dataout_q <= beat_data;
        end
    end
endmodule

// File: tb/tb_burst_rdmem_model.sv
// Bench for burst_rdmem_model: three instances (defaults, zero latency, short
// 64-bit bursts) each checked every cycle against a transaction-level model.
module tb_burst_rdmem_model;
    typedef struct {
        int          cyc;
        logic [63:0] data;
        bit          last;
    } beat_t;

    logic        clk = 1'b0;
    logic [2:0]  rstn = 3'b000;
    logic [2:0]  req  = 3'b000;
    logic [31:0] addr [3] = '{32'h0, 32'h0, 32'h0};
    wire  [2:0]  ack, dv, lst, busy;
    wire  [2:0]  qlvl [3];
    wire  [63:0] dout [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int dv_run = 0;

    int first_dv, last_dv, dv_cnt, last_cnt, q0_cyc;
    logic [63:0] first_data, last_data;

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input int inst, input string name,
                               input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL inst%0d %s at cycle %0d: got 0x%0h expected 0x%0h",
                     inst, name, cyc, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 0 : 3;
        localparam int BL2 = (gi == 2) ? 2 : 5;
        localparam int DW  = (gi == 2) ? 64 : 32;
        localparam int BL  = 1 << BL2;

        burst_rdmem_model_if #(.ADDR_W(32), .DATA_W(DW), .QLVL_W(3)) mif ();

        burst_rdmem_model #(
            .ADDR_W(32), .DATA_W(DW), .BURST_LOG2(BL2), .LATENCY(LAT), .QDEPTH(4)
        ) dut (
            .clk(clk),
            .reset_n(rstn[gi]),
            .bus(mif.slave)
        );

        assign mif.mem_rdaddr = addr[gi];
        assign mif.mem_rdreq  = req[gi];
        assign ack[gi]  = mif.mem_rdack;
        assign dv[gi]   = mif.mem_datavalid;
        assign lst[gi]  = mif.mem_last;
        assign busy[gi] = mif.mem_busy;
        assign qlvl[gi] = mif.mem_qlevel;
        assign dout[gi] = 64'(mif.mem_dataout);

        logic [31:0] mq [$];
        beat_t       sched [$];
        logic [63:0] held = '0;
        bit          exp_dv = 1'b0;
        bit          exp_last = 1'b0;
        int          n = 0;
        int          eng_free = 0;

        // Model: a pop schedules a whole burst; the engine is free again after its last beat.
        always @(posedge clk or negedge rstn[gi]) begin
            if (!rstn[gi]) begin
                mq.delete();
                sched.delete();
                n        = 0;
                eng_free = 0;
                held     = '0;
                exp_dv   = 1'b0;
                exp_last = 1'b0;
            end else begin
                bit          do_push;
                logic [31:0] ln;
                beat_t       b;
                do_push = req[gi] && (mq.size() < 4);
                n++;
                if (mq.size() > 0 && n >= eng_free) begin
                    ln = mq.pop_front();
                    for (int k = 0; k < BL; k++) begin
                        b.cyc  = n + LAT + 1 + k;
                        b.data = 64'(ln | 32'(k));
                        b.last = (k == BL - 1);
                        sched.push_back(b);
                    end
                    eng_free = n + LAT + BL;
                end
                if (do_push) mq.push_back(addr[gi] & ~32'(BL - 1));
                exp_dv   = 1'b0;
                exp_last = 1'b0;
                if (sched.size() > 0 && sched[0].cyc == n) begin
                    b        = sched.pop_front();
                    exp_dv   = 1'b1;
                    exp_last = b.last;
                    held     = b.data;
                end
            end
        end

        // Compare every output against the model away from the clock edge.
        always @(negedge clk) begin
            if (mon_en) begin
                checkOutput(gi, "ack", ack[gi], req[gi] && (mq.size() < 4));
                checkOutput(gi, "datavalid", dv[gi], exp_dv);
                checkOutput(gi, "last", lst[gi], exp_last);
                checkOutput(gi, "dataout", dout[gi], held);
                checkOutput(gi, "busy", busy[gi], (mq.size() > 0) || (n < eng_free));
                checkOutput(gi, "qlevel", qlvl[gi], mq.size());
            end
        end
    end

    task automatic step(input int inst);
        @(posedge clk);
        #1;
        if (dv[inst]) dv_run++;
    endtask

    task automatic applyStimulus(input int inst, input logic [31:0] a, input bit r);
        addr[inst] = a;
        req[inst]  = r;
        #1;
    endtask

    task automatic watchOutput(input int inst, input int ncyc);
        first_dv = -1; last_dv = -1; dv_cnt = 0; last_cnt = 0; q0_cyc = -1;
        first_data = '0; last_data = '0;
        for (int i = 0; i < ncyc; i++) begin
            step(inst);
            if (dv[inst]) begin
                if (first_dv < 0) begin
                    first_dv   = cyc;
                    first_data = dout[inst];
                end
                last_dv = cyc;
                dv_cnt++;
                if (lst[inst]) begin
                    last_cnt++;
                    last_data = dout[inst];
                end
            end
            if (q0_cyc < 0 && qlvl[inst] == 3'd0) q0_cyc = cyc;
        end
    endtask

    // Hard stop in case something never terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        int e0, acks, extra, found;

        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput(i, "reset_datavalid", dv[i], 1'b0);
            checkOutput(i, "reset_busy", busy[i], 1'b0);
            checkOutput(i, "reset_qlevel", qlvl[i], 3'd0);
            checkOutput(i, "reset_dataout", dout[i], 64'h0);
        end
        rstn = 3'b111;
        step(0);

        $display("[TB] single aligned request");
        applyStimulus(0, 32'h0000_0000, 1'b1);
        checkOutput(0, "t1_ack", ack[0], 1'b1);
        e0 = cyc + 1;
        step(0);
        applyStimulus(0, 32'h0, 1'b0);
        watchOutput(0, 40);
        checkOutput(0, "t1_first_delay", first_dv - e0, 4);
        checkOutput(0, "t1_beats", dv_cnt, 32);
        checkOutput(0, "t1_contig", last_dv - first_dv, 31);
        checkOutput(0, "t1_last_count", last_cnt, 1);
        checkOutput(0, "t1_first_data", first_data, 64'h0);
        checkOutput(0, "t1_last_data", last_data, 64'h1F);
        checkOutput(0, "t1_busy_after", busy[0], 1'b0);

        $display("[TB] unaligned request");
        applyStimulus(0, 32'h2000_001C, 1'b1);
        step(0);
        applyStimulus(0, 32'h0, 1'b0);
        watchOutput(0, 40);
        checkOutput(0, "t2_beats", dv_cnt, 32);
        checkOutput(0, "t2_first_data", first_data, 64'h2000_0000);
        checkOutput(0, "t2_last_data", last_data, 64'h2000_001F);

        $display("[TB] back-to-back bursts with zero latency");
        applyStimulus(1, 32'h40, 1'b1);
        e0 = cyc + 1;
        step(1);
        checkOutput(1, "t3_qlevel_a", qlvl[1], 3'd1);
        applyStimulus(1, 32'h80, 1'b1);
        step(1);
        checkOutput(1, "t3_qlevel_b", qlvl[1], 3'd1);
        applyStimulus(1, 32'h0, 1'b0);
        watchOutput(1, 80);
        checkOutput(1, "t3_first_delay", first_dv - e0, 2);
        checkOutput(1, "t3_beats", dv_cnt, 64);
        checkOutput(1, "t3_contig", last_dv - first_dv, 63);
        checkOutput(1, "t3_last_count", last_cnt, 2);
        checkOutput(1, "t3_last_data", last_data, 64'h9F);
        checkOutput(1, "t3_qlevel_zero", q0_cyc - e0, 33);

        $display("[TB] queue fill and backpressure");
        dv_run = 0;
        applyStimulus(0, 32'h1000, 1'b1);
        e0 = cyc + 1;
        step(0);
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 32'h2000 + 32'(k) * 32'h20, 1'b1);
            if (ack[0]) acks++;
            step(0);
        end
        checkOutput(0, "t4_acks_in_8", acks, 4);
        extra = -1;
        for (int k = 0; k < 60 && extra < 0; k++) begin
            applyStimulus(0, 32'h2100 + 32'(k) * 32'h20, 1'b1);
            if (ack[0]) extra = cyc + 1;
            step(0);
        end
        checkOutput(0, "t4_ack_after_pop", extra - e0, 36);
        applyStimulus(0, 32'h0, 1'b0);
        for (int k = 0; k < 300 && busy[0]; k++) step(0);
        checkOutput(0, "t4_drained", busy[0], 1'b0);
        checkOutput(0, "t4_total_beats", dv_run, 192);

        $display("[TB] asynchronous reset mid-burst");
        applyStimulus(0, 32'h3000, 1'b1);
        step(0);
        applyStimulus(0, 32'h3020, 1'b1);
        step(0);
        applyStimulus(0, 32'h3040, 1'b1);
        step(0);
        applyStimulus(0, 32'h0, 1'b0);
        checkOutput(0, "t5_queued", qlvl[0], 3'd2);
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            step(0);
            if (dv[0] && dout[0][4:0] == 5'd10) found = 1;
        end
        checkOutput(0, "t5_beat10_seen", found, 1);
        #2;
        rstn[0] = 1'b0;
        #1;
        checkOutput(0, "t5_rst_datavalid", dv[0], 1'b0);
        checkOutput(0, "t5_rst_last", lst[0], 1'b0);
        checkOutput(0, "t5_rst_busy", busy[0], 1'b0);
        checkOutput(0, "t5_rst_qlevel", qlvl[0], 3'd0);
        step(0);
        step(0);
        rstn[0] = 1'b1;
        dv_run = 0;
        repeat (60) step(0);
        checkOutput(0, "t5_no_beats_after", dv_run, 0);
        checkOutput(0, "t5_idle_after", busy[0], 1'b0);

        $display("[TB] short 64-bit bursts with latency 3");
        applyStimulus(2, 32'h100, 1'b1);
        e0 = cyc + 1;
        step(2);
        applyStimulus(2, 32'h0, 1'b0);
        watchOutput(2, 20);
        checkOutput(2, "t6_first_delay", first_dv - e0, 5);
        checkOutput(2, "t6_beats", dv_cnt, 4);
        checkOutput(2, "t6_first_data", first_data, 64'h100);
        checkOutput(2, "t6_last_data", last_data, 64'h103);
        checkOutput(2, "t6_last_count", last_cnt, 1);

        step(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
